// File: rtl/i2s_adc_rx.sv
// -----------------------------------------------------------------------------
// i2s_adc_rx
//
// Deserialises the codec ADC's I2S stream into MSB-aligned signed 32-bit
// stereo samples and emits one audio_valid strobe per complete L/R frame.
// BCLK, LRCLK and ADCDAT are codec-driven and asynchronous to clock; the
// system clock must run at least 8x the BCLK frequency.
//
// Optional feature macro: I2S_RX_FRAME_CHECK_EN
//   When defined, adds a sticky frame_err flag and its err_clear input.
//   When undefined, malformed frames are still dropped, just silently.
//
// Parameters:
//   DATA_BITS    codec word length in bits (8..32)
//   SYNC_STAGES  synchroniser flops per async input (2 or 3)
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low reset
//   i2s_bclk     codec bit clock (async)
//   i2s_lrclk    codec word select, 0 = left, 1 = right (async)
//   i2s_adcdat   codec serial ADC data, MSB first (async)
//   audio_out_L  signed left sample, MSB-aligned, held between strobes
//   audio_out_R  signed right sample, MSB-aligned, held between strobes
//   audio_valid  one-clock strobe, both outputs update on this cycle
//   frame_err    sticky framing error flag (feature only)
//   err_clear    clears frame_err; a simultaneous new error wins (feature only)
// -----------------------------------------------------------------------------
module i2s_adc_rx #(
  parameter int DATA_BITS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i2s_bclk,
  input  logic               i2s_lrclk,
  input  logic               i2s_adcdat,
  output logic signed [31:0] audio_out_L,
  output logic signed [31:0] audio_out_R,
  output logic               audio_valid
`ifdef I2S_RX_FRAME_CHECK_EN
  ,
  output logic               frame_err,
  input  logic               err_clear
`endif
);

  localparam int              CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    SEEK,
    LEFT,
    WAIT_R,
    RIGHT,
    EMIT
  } state_t;

  // Places a codec word at the top of the 32-bit output word; the word MSB
  // becomes the sign bit and the unused LSBs are zero.
  function automatic logic signed [31:0] align_word(input logic [DATA_BITS-1:0] w);
    logic [31:0] ext;
    ext = 32'(w);
    return $signed(ext << (32 - DATA_BITS));
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: synchronisers and BCLK rising-edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bclk_sync_p0;
  logic [SYNC_STAGES-1:0] lrclk_sync_p0;
  logic [SYNC_STAGES-1:0] adcdat_sync_p0;
  logic                   bclk_dly_p0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_sync_p0   <= '0;
      lrclk_sync_p0  <= '0;
      adcdat_sync_p0 <= '0;
      bclk_dly_p0    <= 1'b0;
    end else begin
      bclk_sync_p0   <= {bclk_sync_p0[SYNC_STAGES-2:0], i2s_bclk};
      lrclk_sync_p0  <= {lrclk_sync_p0[SYNC_STAGES-2:0], i2s_lrclk};
      adcdat_sync_p0 <= {adcdat_sync_p0[SYNC_STAGES-2:0], i2s_adcdat};
      bclk_dly_p0    <= bclk_sync_p0[SYNC_STAGES-1];
    end
  end

  logic bit_evt_p0;
  logic lr_p0;
  logic dat_p0;

  assign bit_evt_p0 = bclk_sync_p0[SYNC_STAGES-1] & ~bclk_dly_p0;
  assign lr_p0      = lrclk_sync_p0[SYNC_STAGES-1];
  assign dat_p0     = adcdat_sync_p0[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stage p1: bit capture and frame FSM
  // ---------------------------------------------------------------------------
  state_t                 state;
  logic                   lr_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_BITS-2:0]   shreg;
  logic [DATA_BITS-1:0]   left_hold;
  logic [DATA_BITS-1:0]   right_hold;

  logic                   slot_p1;
  logic                   data_evt_p1;
  logic                   word_done_p1;
  logic [DATA_BITS-1:0]   word_next_p1;

  // An LRCLK change marks the I2S one-bit delay slot; its data bit is dropped.
  assign slot_p1      = bit_evt_p0 && (lr_p0 != lr_prev);
  // Only the first DATA_BITS bits after the slot are captured; the rest of a
  // long slot is padding.
  assign data_evt_p1  = bit_evt_p0 && !slot_p1 && (bit_cnt <= CNT_LAST);
  assign word_done_p1 = data_evt_p1 && (bit_cnt == CNT_LAST);
  assign word_next_p1 = {shreg, dat_p0};

`ifdef I2S_RX_FRAME_CHECK_EN
  logic err_set_p1;
  // A slot while still capturing is a short word; a 0->1 slot in LEFT is also
  // the missing-left-completion case.
  assign err_set_p1 = slot_p1 && ((state == LEFT) || (state == RIGHT));
`endif

  // ---------------------------------------------------------------------------
  // Stage p2: registered outputs
  // ---------------------------------------------------------------------------
  logic vld_p2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= SEEK;
      lr_prev     <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      right_hold  <= '0;
      audio_out_L <= '0;
      audio_out_R <= '0;
      vld_p2      <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      frame_err   <= 1'b0;
`endif
    end else begin
      vld_p2 <= 1'b0;

      if (bit_evt_p0) begin
        lr_prev <= lr_p0;
      end

      if (slot_p1) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (data_evt_p1) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= word_next_p1[DATA_BITS-2:0];
      end

      // EMIT always directly follows a bit event, and bit events are at least
      // eight clocks apart, so nothing else can need the FSM on that cycle.
      if (state == EMIT) begin
        audio_out_L <= align_word(left_hold);
        audio_out_R <= align_word(right_hold);
        vld_p2      <= 1'b1;
        state       <= SEEK;
      end else if (slot_p1) begin
        if (!lr_p0) begin
          // 1->0 slot: start of a left word, from any waiting state. An
          // unfinished right word is abandoned here.
          state <= LEFT;
        end else if (state == WAIT_R) begin
          state <= RIGHT;
        end else begin
          // 0->1 slot without a completed left word: drop this right word.
          state <= SEEK;
        end
      end else if (word_done_p1) begin
        if (state == LEFT) begin
          left_hold <= word_next_p1;
          state     <= WAIT_R;
        end else if (state == RIGHT) begin
          right_hold <= word_next_p1;
          state      <= EMIT;
        end
      end

`ifdef I2S_RX_FRAME_CHECK_EN
      if (err_set_p1) begin
        frame_err <= 1'b1;
      end else if (err_clear) begin
        frame_err <= 1'b0;
      end
`endif
    end
  end

  assign audio_valid = vld_p2;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_adc_rx
//
// Directed bench for i2s_adc_rx. An I2S source drives bits through tasks; a
// stream-level model turns the bit stream into expected L/R frames, and a
// compare process checks strobes, strobe width, latency and held outputs on
// every clock. Literal expectations pin the model for the directed frames.
// -----------------------------------------------------------------------------
module tb_i2s_adc_rx;

  localparam int DB = 24;

  logic               clock = 1'b0;
  logic               reset;
  logic               bclk;
  logic               lrclk;
  logic               adcdat;
  logic signed [31:0] audio_out_L;
  logic signed [31:0] audio_out_R;
  logic               audio_valid;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic               frame_err;
  logic               err_clear;
`endif

  i2s_adc_rx #(
    .DATA_BITS   (DB),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i2s_bclk    (bclk),
    .i2s_lrclk   (lrclk),
    .i2s_adcdat  (adcdat),
    .audio_out_L (audio_out_L),
    .audio_out_R (audio_out_R),
    .audio_valid (audio_valid)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err   (frame_err),
    .err_clear   (err_clear)
`endif
  );

  initial forever #5 clock = ~clock;

  int  checks    = 0;
  int  errors    = 0;
  int  n_strobes = 0;
  int  half_ns   = 80;
  time last_rise = 0;

  logic [31:0] exp_l[$];
  logic [31:0] exp_r[$];
  logic [31:0] held_l   = '0;
  logic [31:0] held_r   = '0;
  logic        prev_vld = 1'b0;

  // Stream model state
  logic          m_prev_lr;
  bit            m_left_start;
  bit            m_left_done;
  bit            m_right_ok;
  int            m_cnt;
  logic [DB-1:0] m_word;
  logic [DB-1:0] m_left_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_prev_lr    = 1'b0;
    m_left_start = 0;
    m_left_done  = 0;
    m_right_ok   = 0;
    m_cnt        = 0;
    m_word       = '0;
    m_left_val   = '0;
    exp_l.delete();
    exp_r.delete();
  endtask

  // Frame rules: a left word counts only if its slot began with a 1->0 LRCLK
  // change; a right word yields a frame only if it directly follows a
  // completed left word. Words end after DB bits; shorter slots abort them.
  task automatic model_bit(input logic lr, input logic d);
    logic [31:0] al;
    logic [31:0] ar;
    if (lr != m_prev_lr) begin
      m_cnt  = 0;
      m_word = '0;
      if (!lr) begin
        m_left_start = 1;
      end else begin
        m_right_ok   = m_left_done;
        m_left_start = 0;
      end
      m_left_done = 0;
    end else if (m_cnt < DB) begin
      m_word = (m_word << 1) | DB'(d);
      m_cnt++;
      if (m_cnt == DB) begin
        if (!lr && m_left_start) begin
          m_left_val  = m_word;
          m_left_done = 1;
        end
        if (lr && m_right_ok) begin
          al = 32'(m_left_val) << (32 - DB);
          ar = 32'(m_word) << (32 - DB);
          exp_l.push_back(al);
          exp_r.push_back(ar);
          m_right_ok = 0;
        end
      end
    end
    m_prev_lr = lr;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    lrclk  = lr;
    adcdat = d;
    model_bit(lr, d);
    #(half_ns) bclk = 1'b1;
    last_rise = $time;
    #(half_ns) bclk = 1'b0;
  endtask

  task automatic send_word(input logic lr, input logic [DB-1:0] w, input int nbits, input int pad);
    send_bit(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < nbits; i++) send_bit(lr, w[DB-1-i]);
    for (int i = 0; i < pad; i++) send_bit(lr, 1'b1);
  endtask

  task automatic send_frame(input logic [DB-1:0] l, input logic [DB-1:0] r, input int pad);
    send_word(1'b0, l, DB, pad);
    send_word(1'b1, r, DB, pad);
  endtask

  // Compare process: every clock, away from the active edge.
  always @(negedge clock) begin
    time delta;
    if (!reset) begin
      chk("reset_L", audio_out_L, 32'h0);
      chk("reset_R", audio_out_R, 32'h0);
      chk("reset_valid", {31'h0, audio_valid}, 32'h0);
      held_l   = '0;
      held_r   = '0;
      prev_vld = 1'b0;
    end else begin
      if (audio_valid) begin
        n_strobes++;
        chk("strobe_width", {31'h0, prev_vld}, 32'h0);
        delta = $time - last_rise;
        chk("strobe_latency", {31'h0, (delta >= 36 && delta <= 45)}, 32'h1);
        checks++;
        if (exp_l.size() == 0) begin
          errors++;
          $display("FAIL spurious_strobe actual=L%h/R%h required=no strobe", audio_out_L, audio_out_R);
        end else begin
          held_l = exp_l.pop_front();
          held_r = exp_r.pop_front();
          chk("strobe_L", audio_out_L, held_l);
          chk("strobe_R", audio_out_R, held_r);
        end
      end else begin
        chk("hold_L", audio_out_L, held_l);
        chk("hold_R", audio_out_R, held_r);
      end
      prev_vld = audio_valid;
    end
  end

  initial begin
    int            s0;
    logic [DB-1:0] w5;
    logic [DB-1:0] rl;
    logic [DB-1:0] rr;

    reset  = 1'b0;
    bclk   = 1'b0;
    lrclk  = 1'b1;
    adcdat = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
    err_clear = 1'b0;
`endif
    model_reset();
    #2;
    #40;
    chk("por_L", audio_out_L, 32'h0);
    chk("por_R", audio_out_R, 32'h0);
    chk("por_valid", {31'h0, audio_valid}, 32'h0);
`ifdef I2S_RX_FRAME_CHECK_EN
    chk("por_frame_err", {31'h0, frame_err}, 32'h0);
`endif
    reset = 1'b1;
    #20;

    // Basic extreme values, tight 50-BCLK frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    s0 = n_strobes;
    send_frame(24'h7FFFFF, 24'h800000, 0);
    #200;
    chk("t1_strobes", n_strobes - s0, 1);
    chk("t1_L", audio_out_L, 32'h7FFFFF00);
    chk("t1_R", audio_out_R, 32'h80000000);

    // 64-BCLK frame: padding driven high must be ignored
    s0 = n_strobes;
    send_frame(24'hFFFFFF, 24'h000001, 7);
    #200;
    chk("t2_strobes", n_strobes - s0, 1);
    chk("t2_L", audio_out_L, 32'hFFFFFF00);
    chk("t2_R", audio_out_R, 32'h00000100);
`ifdef I2S_RX_FRAME_CHECK_EN
    chk("t2_frame_err", {31'h0, frame_err}, 32'h0);
`endif

    // Reset, then the stream resumes mid-right-word
    reset = 1'b0;
    #1;
    chk("t3_rst_L", audio_out_L, 32'h0);
    chk("t3_rst_R", audio_out_R, 32'h0);
    model_reset();
    #49;
    reset = 1'b1;
    #20;
    s0 = n_strobes;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    #200;
    chk("t3_partial_strobes", n_strobes - s0, 0);
    send_frame(24'h123456, 24'hABCDEF, 0);
    #200;
    chk("t3_strobes", n_strobes - s0, 1);
    chk("t3_L", audio_out_L, 32'h12345600);
    chk("t3_R", audio_out_R, 32'hABCDEF00);
    send_frame(24'h00FF00, 24'hFF00FF, 2);
    #200;
    chk("t3b_L", audio_out_L, 32'h00FF0000);
    chk("t3b_R", audio_out_R, 32'hFF00FF00);

    // Left word truncated to 12 bits: frame dropped, outputs held
    s0 = n_strobes;
    send_word(1'b0, 24'h5A5A5A, 12, 0);
    send_word(1'b1, 24'h3C3C3C, DB, 0);
    #200;
    chk("t4_strobes", n_strobes - s0, 0);
    chk("t4_hold_L", audio_out_L, 32'h00FF0000);
    chk("t4_hold_R", audio_out_R, 32'hFF00FF00);
`ifdef I2S_RX_FRAME_CHECK_EN
    chk("t4_frame_err_set", {31'h0, frame_err}, 32'h1);
    err_clear = 1'b1;
    #20;
    err_clear = 1'b0;
    #10;
    chk("t4_frame_err_clr", {31'h0, frame_err}, 32'h0);
`endif

    // Right word truncated: dropped when the next left slot starts
    s0 = n_strobes;
    send_word(1'b0, 24'h111111, DB, 0);
    send_word(1'b1, 24'h222222, 12, 0);
    send_frame(24'h333333, 24'h444444, 0);
    #200;
    chk("t4b_strobes", n_strobes - s0, 1);
    chk("t4b_L", audio_out_L, 32'h33333300);
    chk("t4b_R", audio_out_R, 32'h44444400);
`ifdef I2S_RX_FRAME_CHECK_EN
    chk("t4b_frame_err_set", {31'h0, frame_err}, 32'h1);
    err_clear = 1'b1;
    #20;
    err_clear = 1'b0;
    #10;
    chk("t4b_frame_err_clr", {31'h0, frame_err}, 32'h0);
`endif

    // Reset at bit 10 of a right word, held for 5 clocks
    w5 = 24'h0F0F0F;
    s0 = n_strobes;
    send_word(1'b0, 24'h765432, DB, 0);
    send_word(1'b1, w5, 10, 0);
    reset = 1'b0;
    #1;
    chk("t5_rst_L", audio_out_L, 32'h0);
    chk("t5_rst_R", audio_out_R, 32'h0);
    chk("t5_rst_valid", {31'h0, audio_valid}, 32'h0);
    model_reset();
    #49;
    reset = 1'b1;
    for (int i = 0; i < 14; i++) send_bit(1'b1, w5[13-i]);
    send_frame(24'h89ABCD, 24'h654321, 0);
    #200;
    chk("t5_strobes", n_strobes - s0, 1);
    chk("t5_L", audio_out_L, 32'h89ABCD00);
    chk("t5_R", audio_out_R, 32'h65432100);

    // 100 back-to-back random frames at BCLK = clock/8
    half_ns = 40;
    s0 = n_strobes;
    for (int f = 0; f < 100; f++) begin
      rl = DB'($urandom);
      rr = DB'($urandom);
      send_frame(rl, rr, $urandom_range(0, 2));
    end
    #200;
    chk("t6_strobes", n_strobes - s0, 100);
    chk("t6_queue_empty", exp_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
